// File: rtl/cluster_boot_pkg.sv
// Shared types and helpers for the cluster boot sequencer: FSM states,
// default register offsets, lowest-set-bit search and per-cluster address math.
package cluster_boot_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DELAY,
        ST_WR_REQ,
        ST_WR_RSP,
        ST_WAKE,
        ST_POLL_WAIT,
        ST_RD_REQ,
        ST_RD_RSP,
        ST_DONE,
        ST_ERROR
    } boot_state_e;

    localparam int unsigned MaxIdxW   = 5;
    localparam int unsigned MaskSrchW = 32;

    localparam logic [47:0] DefaultPeriBase       = 48'h0000_0012_0000;
    localparam logic [47:0] DefaultClusterStride  = 48'h0000_0004_0000;
    localparam logic [47:0] DefaultBootCtrlOffset = 48'h0000_0000_0058;
    localparam logic [47:0] DefaultEocOffset      = 48'h0000_0000_0060;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [MaxIdxW-1:0] lowest_set(input logic [MaskSrchW-1:0] mask);
        logic [MaxIdxW-1:0] idx;
        idx = '0;
        for (int i = MaskSrchW - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = MaxIdxW'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [63:0] cluster_addr(input logic [63:0]        base,
                                                 input logic [63:0]        stride,
                                                 input logic [MaxIdxW-1:0] idx,
                                                 input logic [63:0]        offset);
        return base + (stride * 64'(idx)) + offset;
    endfunction

endpackage

// File: rtl/cluster_boot_mask_iter.sv
// Registered walker over a cluster mask: current index, the first index seen at
// load time, the next higher set bit and a flag when no higher bit remains.
module cluster_boot_mask_iter
    import cluster_boot_pkg::*;
#(
    parameter int unsigned NumClusters = 4,
    localparam int unsigned IdxW = idx_width(NumClusters)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_i,
    input  logic [NumClusters-1:0] mask_i,
    input  logic                   advance_i,
    output logic [IdxW-1:0]        cur_idx_o,
    output logic [IdxW-1:0]        first_idx_o,
    output logic [IdxW-1:0]        next_idx_o,
    output logic                   none_left_o
);

    // rem_q holds only the set bits strictly above the current index
    logic [NumClusters-1:0] rem_q, rem_d;
    logic [IdxW-1:0]        cur_q, cur_d;
    logic [IdxW-1:0]        first_q, first_d;
    logic [IdxW-1:0]        next_q, next_d;
    logic                   none_q, none_d;
    logic [NumClusters-1:0] seed;

    always_comb begin
        rem_d   = rem_q;
        cur_d   = cur_q;
        first_d = first_q;
        next_d  = next_q;
        none_d  = none_q;
        seed    = '0;
        if (load_i) begin
            cur_d   = IdxW'(lowest_set(MaskSrchW'(mask_i)));
            first_d = cur_d;
            seed    = mask_i & ~(NumClusters'(1) << cur_d);
        end else if (advance_i) begin
            cur_d = next_q;
            seed  = rem_q & ~(NumClusters'(1) << next_q);
        end
        if (load_i || advance_i) begin
            rem_d  = seed;
            next_d = IdxW'(lowest_set(MaskSrchW'(seed)));
            none_d = (seed == '0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q   <= '0;
            cur_q   <= '0;
            first_q <= '0;
            next_q  <= '0;
            none_q  <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            cur_q   <= cur_d;
            first_q <= first_d;
            next_q  <= next_d;
            none_q  <= none_d;
        end
    end

    assign cur_idx_o   = cur_q;
    assign first_idx_o = first_q;
    assign next_idx_o  = next_q;
    assign none_left_o = none_q;

endmodule

// File: rtl/cluster_boot_sequencer.sv
// Boots a cluster array: writes the entry point to each enabled cluster's
// BOOT_CONTROL register, pulses debug_req, then optionally polls EOC for an exit code.
module cluster_boot_sequencer
    import cluster_boot_pkg::*;
#(
    parameter int unsigned          NumClusters     = 4,
    parameter int unsigned          CoresPerCluster = 4,
    parameter int unsigned          AddrWidth       = 48,
    parameter int unsigned          DataWidth       = 64,
    parameter logic [AddrWidth-1:0] PeriBaseAddr    = AddrWidth'(DefaultPeriBase),
    parameter logic [AddrWidth-1:0] ClusterStride   = AddrWidth'(DefaultClusterStride),
    parameter logic [AddrWidth-1:0] BootCtrlOffset  = AddrWidth'(DefaultBootCtrlOffset),
    parameter logic [AddrWidth-1:0] EocOffset       = AddrWidth'(DefaultEocOffset),
    parameter int unsigned          InitDelay       = 1000,
    parameter int unsigned          WakeCycles      = 1,
    parameter bit                   PollEoc         = 1'b1,
    parameter int unsigned          PollInterval    = 64
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   start_i,
    input  logic [31:0]                            entry_point_i,
    input  logic [NumClusters-1:0]                 cluster_mask_i,
    output logic [AddrWidth-1:0]                   req_addr_o,
    output logic [DataWidth-1:0]                   req_data_o,
    output logic                                   req_write_o,
    output logic [DataWidth/8-1:0]                 req_strb_o,
    output logic                                   req_valid_o,
    input  logic                                   req_ready_i,
    input  logic [DataWidth-1:0]                   rsp_data_i,
    input  logic                                   rsp_error_i,
    input  logic                                   rsp_valid_i,
    output logic                                   rsp_ready_o,
    output logic [NumClusters*CoresPerCluster-1:0] debug_req_o,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic                                   error_o,
    output logic [30:0]                            exit_code_o
);

    localparam int unsigned IdxW   = idx_width(NumClusters);
    localparam int unsigned StrbW  = DataWidth / 8;
    localparam int unsigned DbgW   = NumClusters * CoresPerCluster;
    localparam int unsigned CntMax0 = (InitDelay > WakeCycles) ? InitDelay : WakeCycles;
    localparam int unsigned CntMax  = (CntMax0 > PollInterval) ? CntMax0 : PollInterval;
    localparam int unsigned CntW    = $clog2(CntMax + 1);

    boot_state_e            state_q, state_d;
    logic [NumClusters-1:0] mask_q, mask_d;
    logic [31:0]            entry_q, entry_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [30:0]            exit_q, exit_d;

    logic [AddrWidth-1:0]   req_addr_q, req_addr_d;
    logic [DataWidth-1:0]   req_data_q, req_data_d;
    logic                   req_write_q, req_write_d;
    logic [StrbW-1:0]       req_strb_q, req_strb_d;
    logic                   req_valid_q, req_valid_d;
    logic                   rsp_ready_q, rsp_ready_d;
    logic [DbgW-1:0]        debug_q, debug_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;

    logic                   iter_load, iter_adv;
    logic [IdxW-1:0]        iter_cur_idx, iter_first_idx, iter_next_idx;
    logic                   iter_none_left;
    logic [IdxW-1:0]        wr_idx;
    logic                   unused_rsp_data_c;

    assign unused_rsp_data_c = ^rsp_data_i[DataWidth-1:32];

    cluster_boot_mask_iter #(
        .NumClusters (NumClusters)
    ) u_mask_iter (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (iter_load),
        .mask_i      (cluster_mask_i),
        .advance_i   (iter_adv),
        .cur_idx_o   (iter_cur_idx),
        .first_idx_o (iter_first_idx),
        .next_idx_o  (iter_next_idx),
        .none_left_o (iter_none_left)
    );

    // Next-state and sequencing context
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        entry_d   = entry_q;
        cnt_d     = cnt_q;
        exit_d    = exit_q;
        iter_load = 1'b0;
        iter_adv  = 1'b0;
        wr_idx    = iter_cur_idx;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) begin
                    mask_d    = cluster_mask_i;
                    entry_d   = entry_point_i;
                    exit_d    = '0;
                    cnt_d     = CntW'(1);
                    iter_load = 1'b1;
                    wr_idx    = IdxW'(lowest_set(MaskSrchW'(cluster_mask_i)));
                    if (cluster_mask_i == '0) begin
                        state_d = ST_DONE;
                    end else if (InitDelay == 0) begin
                        state_d = ST_WR_REQ;
                    end else begin
                        state_d = ST_DELAY;
                    end
                end
            end
            ST_DELAY: begin
                if (cnt_q == CntW'(InitDelay)) begin
                    state_d = ST_WR_REQ;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            ST_WR_REQ: begin
                if (req_ready_i) begin
                    state_d = ST_WR_RSP;
                end
            end
            ST_WR_RSP: begin
                if (rsp_valid_i) begin
                    if (rsp_error_i) begin
                        state_d = ST_ERROR;
                    end else if (iter_none_left) begin
                        state_d = ST_WAKE;
                        cnt_d   = CntW'(1);
                    end else begin
                        state_d  = ST_WR_REQ;
                        iter_adv = 1'b1;
                        wr_idx   = iter_next_idx;
                    end
                end
            end
            ST_WAKE: begin
                if (cnt_q == CntW'(WakeCycles)) begin
                    cnt_d   = CntW'(1);
                    state_d = PollEoc ? ST_POLL_WAIT : ST_DONE;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            ST_POLL_WAIT: begin
                if (cnt_q == CntW'(PollInterval)) begin
                    state_d = ST_RD_REQ;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            ST_RD_REQ: begin
                if (req_ready_i) begin
                    state_d = ST_RD_RSP;
                end
            end
            ST_RD_RSP: begin
                if (rsp_valid_i) begin
                    if (rsp_error_i) begin
                        state_d = ST_ERROR;
                    end else if (rsp_data_i[0]) begin
                        exit_d  = rsp_data_i[31:1];
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = CntW'(1);
                        state_d = ST_POLL_WAIT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs derived from the upcoming state
    always_comb begin
        busy_d      = !(state_d inside {ST_IDLE, ST_DONE, ST_ERROR});
        done_d      = (state_d == ST_DONE);
        error_d     = (state_d == ST_ERROR);
        rsp_ready_d = (state_d inside {ST_WR_RSP, ST_RD_RSP});
        req_valid_d = (state_d inside {ST_WR_REQ, ST_RD_REQ});
        req_addr_d  = '0;
        req_data_d  = '0;
        req_write_d = 1'b0;
        req_strb_d  = '0;
        debug_d     = '0;
        if (req_valid_d && (state_d == state_q)) begin
            req_addr_d  = req_addr_q;
            req_data_d  = req_data_q;
            req_write_d = req_write_q;
            req_strb_d  = req_strb_q;
        end else if (state_d == ST_WR_REQ) begin
            req_addr_d  = AddrWidth'(cluster_addr(64'(PeriBaseAddr), 64'(ClusterStride),
                                                  MaxIdxW'(wr_idx), 64'(BootCtrlOffset)));
            req_data_d  = DataWidth'(entry_d);
            req_write_d = 1'b1;
            req_strb_d  = '1;
        end else if (state_d == ST_RD_REQ) begin
            req_addr_d  = AddrWidth'(cluster_addr(64'(PeriBaseAddr), 64'(ClusterStride),
                                                  MaxIdxW'(iter_first_idx), 64'(EocOffset)));
            req_strb_d  = '1;
        end
        if (state_d == ST_WAKE) begin
            for (int c = 0; c < NumClusters; c++) begin
                debug_d[c*CoresPerCluster +: CoresPerCluster] = {CoresPerCluster{mask_d[c]}};
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            entry_q     <= '0;
            cnt_q       <= '0;
            exit_q      <= '0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_write_q <= 1'b0;
            req_strb_q  <= '0;
            req_valid_q <= 1'b0;
            rsp_ready_q <= 1'b0;
            debug_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            entry_q     <= entry_d;
            cnt_q       <= cnt_d;
            exit_q      <= exit_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            req_write_q <= req_write_d;
            req_strb_q  <= req_strb_d;
            req_valid_q <= req_valid_d;
            rsp_ready_q <= rsp_ready_d;
            debug_q     <= debug_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign req_addr_o  = req_addr_q;
    assign req_data_o  = req_data_q;
    assign req_write_o = req_write_q;
    assign req_strb_o  = req_strb_q;
    assign req_valid_o = req_valid_q;
    assign rsp_ready_o = rsp_ready_q;
    assign debug_req_o = debug_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = error_q;
    assign exit_code_o = exit_q;

endmodule

// File: tb/tb_cluster_boot_sequencer.sv
// Self-checking bench for cluster_boot_sequencer: table-driven boot runs against a
// reqrsp slave model with a transaction scoreboard, plus reset and empty-mask sequences.
module tb_cluster_boot_sequencer;

    localparam int unsigned NC       = 4;
    localparam int unsigned CPC      = 4;
    localparam int unsigned AW       = 48;
    localparam int unsigned DW       = 64;
    localparam int unsigned INIT_DLY = 4;
    localparam int unsigned WAKE     = 1;
    localparam int unsigned POLL_IV  = 8;
    localparam logic [AW-1:0] PERI     = 48'h0000_0012_0000;
    localparam logic [AW-1:0] STRIDE   = 48'h0000_0004_0000;
    localparam logic [AW-1:0] BOOT_OFF = 48'h58;
    localparam logic [AW-1:0] EOC_OFF  = 48'h60;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic [31:0]       entry_point_i;
    logic [NC-1:0]     cluster_mask_i;
    logic [AW-1:0]     req_addr_o;
    logic [DW-1:0]     req_data_o;
    logic              req_write_o;
    logic [DW/8-1:0]   req_strb_o;
    logic              req_valid_o;
    logic              req_ready_i;
    logic [DW-1:0]     rsp_data_i;
    logic              rsp_error_i;
    logic              rsp_valid_i;
    logic              rsp_ready_o;
    logic [NC*CPC-1:0] debug_req_o;
    logic              busy_o;
    logic              done_o;
    logic              error_o;
    logic [30:0]       exit_code_o;

    cluster_boot_sequencer #(
        .NumClusters     (NC),
        .CoresPerCluster (CPC),
        .AddrWidth       (AW),
        .DataWidth       (DW),
        .InitDelay       (INIT_DLY),
        .WakeCycles      (WAKE),
        .PollEoc         (1'b1),
        .PollInterval    (POLL_IV)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .entry_point_i  (entry_point_i),
        .cluster_mask_i (cluster_mask_i),
        .req_addr_o     (req_addr_o),
        .req_data_o     (req_data_o),
        .req_write_o    (req_write_o),
        .req_strb_o     (req_strb_o),
        .req_valid_o    (req_valid_o),
        .req_ready_i    (req_ready_i),
        .rsp_data_i     (rsp_data_i),
        .rsp_error_i    (rsp_error_i),
        .rsp_valid_i    (rsp_valid_i),
        .rsp_ready_o    (rsp_ready_o),
        .debug_req_o    (debug_req_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .error_o        (error_o),
        .exit_code_o    (exit_code_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    typedef struct {
        logic [NC-1:0] mask;
        logic [31:0]   entry;
        int            stall;
        int            err_wr;
        int            zero_reads;
        logic [31:0]   eoc_final;
        logic          exp_done;
        logic          exp_err;
        logic [30:0]   exp_exit;
        logic [15:0]   exp_dbg;
    } vec_t;

    txn_t        exp_q[$];
    logic [31:0] eoc_q[$];
    int          rd_cyc[$];
    vec_t        vecs[5];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int stall_cfg  = 0;
    int err_wr_cfg = -1;
    int wr_seen    = 0;
    int dbg_cycles = 0;
    logic [NC*CPC-1:0] dbg_val = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    initial forever begin
        @(negedge clk_i);
        if (debug_req_o != '0) begin
            dbg_cycles++;
            dbg_val = debug_req_o;
        end
    end

    // reqrsp slave: stalls writes by stall_cfg cycles, checks held fields, answers one cycle later
    initial begin
        int            stall_left;
        logic          owe_rsp;
        logic          rsp_is_wr;
        logic [AW-1:0] h_addr;
        logic [DW-1:0] h_data;
        txn_t          t;
        req_ready_i = 1'b0;
        rsp_valid_i = 1'b0;
        rsp_error_i = 1'b0;
        rsp_data_i  = '0;
        stall_left  = -1;
        owe_rsp     = 1'b0;
        rsp_is_wr   = 1'b0;
        h_addr      = '0;
        h_data      = '0;
        forever begin
            @(negedge clk_i);
            req_ready_i = 1'b0;
            rsp_valid_i = 1'b0;
            rsp_error_i = 1'b0;
            rsp_data_i  = '0;
            if (rst_i) begin
                stall_left = -1;
                owe_rsp    = 1'b0;
            end else if (owe_rsp) begin
                if (rsp_ready_o) begin
                    rsp_valid_i = 1'b1;
                    owe_rsp     = 1'b0;
                    if (rsp_is_wr) begin
                        rsp_error_i = (wr_seen == err_wr_cfg);
                        wr_seen++;
                    end else if (eoc_q.size() > 0) begin
                        rsp_data_i = DW'(eoc_q.pop_front());
                    end else begin
                        rsp_data_i = DW'(32'h1);
                    end
                end
            end else begin
                if (stall_left >= 0) begin
                    check("req_valid_held", 64'(req_valid_o), 64'(1));
                end
                if (req_valid_o) begin
                    if (stall_left < 0) begin
                        stall_left = req_write_o ? stall_cfg : 0;
                        h_addr     = req_addr_o;
                        h_data     = req_data_o;
                    end else begin
                        check("req_addr_stable", 64'(req_addr_o), 64'(h_addr));
                        check("req_data_stable", 64'(req_data_o), 64'(h_data));
                    end
                    if (stall_left == 0) begin
                        req_ready_i = 1'b1;
                        stall_left  = -1;
                        owe_rsp     = 1'b1;
                        rsp_is_wr   = req_write_o;
                        if (!req_write_o) begin
                            rd_cyc.push_back(cyc);
                        end
                        check("req_expected", 64'(exp_q.size() != 0), 64'(1));
                        if (exp_q.size() != 0) begin
                            t = exp_q.pop_front();
                            check("req_write", 64'(req_write_o), 64'(t.write));
                            check("req_addr", 64'(req_addr_o), 64'(t.addr));
                            check("req_data", 64'(req_data_o), 64'(t.data));
                            check("req_strb", 64'(req_strb_o), 64'(8'hFF));
                        end
                    end else begin
                        stall_left--;
                    end
                end else begin
                    stall_left = -1;
                end
            end
        end
    end

    task automatic run_vector(input int i);
        vec_t          v;
        int            n_wr;
        int            first;
        int            waited;
        logic [AW-1:0] a;
        v = vecs[i];
        exp_q.delete();
        eoc_q.delete();
        rd_cyc.delete();
        n_wr  = 0;
        first = -1;
        for (int c = 0; c < NC; c++) begin
            if (v.mask[c]) begin
                if (first < 0) first = c;
                if (v.err_wr < 0 || n_wr <= v.err_wr) begin
                    a = PERI + (AW'(c) * STRIDE) + BOOT_OFF;
                    exp_q.push_back('{write: 1'b1, addr: a, data: DW'(v.entry)});
                end
                n_wr++;
            end
        end
        if (v.err_wr < 0) begin
            a = PERI + (AW'(first) * STRIDE) + EOC_OFF;
            for (int r = 0; r <= v.zero_reads; r++) begin
                exp_q.push_back('{write: 1'b0, addr: a, data: '0});
                eoc_q.push_back((r == v.zero_reads) ? v.eoc_final : 32'h0);
            end
        end
        stall_cfg  = v.stall;
        err_wr_cfg = v.err_wr;
        wr_seen    = 0;
        dbg_cycles = 0;
        dbg_val    = '0;

        cluster_mask_i = v.mask;
        entry_point_i  = v.entry;
        start_i        = 1'b1;
        tick();
        start_i        = 1'b0;
        check($sformatf("v%0d_busy_after_start", i), 64'(busy_o), 64'(1));
        check($sformatf("v%0d_done_cleared", i), 64'(done_o), 64'(0));
        check($sformatf("v%0d_error_cleared", i), 64'(error_o), 64'(0));

        waited = 0;
        while (busy_o && waited < 3000) begin
            tick();
            waited++;
        end
        check($sformatf("v%0d_finished_in_budget", i), 64'(busy_o), 64'(0));
        tick();
        tick();
        check($sformatf("v%0d_done", i), 64'(done_o), 64'(v.exp_done));
        check($sformatf("v%0d_error", i), 64'(error_o), 64'(v.exp_err));
        check($sformatf("v%0d_exit_code", i), 64'(exit_code_o), 64'(v.exp_exit));
        check($sformatf("v%0d_dbg_cycles", i), 64'(dbg_cycles), (v.exp_dbg != 0) ? 64'(WAKE) : 64'(0));
        check($sformatf("v%0d_dbg_value", i), 64'(dbg_val), 64'(v.exp_dbg));
        check($sformatf("v%0d_all_txns_seen", i), 64'(exp_q.size()), 64'(0));
        check($sformatf("v%0d_read_count", i), 64'(rd_cyc.size()),
              (v.err_wr < 0) ? 64'(v.zero_reads + 1) : 64'(0));
        for (int k = 1; k < rd_cyc.size(); k++) begin
            check($sformatf("v%0d_poll_spacing", i), 64'(rd_cyc[k] - rd_cyc[k-1]), 64'(POLL_IV + 2));
        end
    endtask

    initial begin
        int waited;
        vecs[0] = '{4'b1011, 32'h8000_1000, 0, -1, 0, 32'h0000_0001, 1'b1, 1'b0, 31'd0,          16'hF0FF};
        vecs[1] = '{4'b0110, 32'h1234_5678, 7, -1, 0, 32'h0000_0003, 1'b1, 1'b0, 31'd1,          16'h0FF0};
        vecs[2] = '{4'b1111, 32'hCAFE_0000, 0,  1, 0, 32'h0000_0001, 1'b0, 1'b1, 31'd0,          16'h0000};
        vecs[3] = '{4'b1111, 32'h0000_2000, 2, -1, 2, 32'h0000_002B, 1'b1, 1'b0, 31'd21,         16'hFFFF};
        vecs[4] = '{4'b1000, 32'hDEAD_BEEC, 0, -1, 0, 32'hFFFF_FFFF, 1'b1, 1'b0, 31'h7FFF_FFFF,  16'hF000};

        rst_i          = 1'b1;
        start_i        = 1'b0;
        entry_point_i  = '0;
        cluster_mask_i = '0;
        tick();
        tick();
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_req_valid", 64'(req_valid_o), 64'(0));
        check("rst_debug", 64'(debug_req_o), 64'(0));
        check("rst_done_error", 64'({done_o, error_o, rsp_ready_o}), 64'(0));
        rst_i = 1'b0;
        tick();
        tick();

        // Empty mask: straight to done, no traffic, no wake
        exp_q.delete();
        dbg_cycles     = 0;
        cluster_mask_i = '0;
        entry_point_i  = 32'h1111_2222;
        start_i        = 1'b1;
        tick();
        start_i        = 1'b0;
        tick();
        check("mask0_done", 64'(done_o), 64'(1));
        for (int k = 0; k < 20; k++) tick();
        check("mask0_no_debug", 64'(dbg_cycles), 64'(0));
        check("mask0_busy", 64'(busy_o), 64'(0));
        check("mask0_done_sticky", 64'(done_o), 64'(1));

        for (int i = 0; i < 5; i++) begin
            run_vector(i);
        end

        // Reset while a write is stalled in WR_REQ
        exp_q.delete();
        stall_cfg      = 50;
        cluster_mask_i = 4'b0001;
        entry_point_i  = 32'h5555_AAAA;
        start_i        = 1'b1;
        tick();
        start_i        = 1'b0;
        waited = 0;
        while (!req_valid_o && waited < 50) begin
            tick();
            waited++;
        end
        check("rst_mid_reached_wr_req", 64'(req_valid_o), 64'(1));
        rst_i = 1'b1;
        #1;
        check("rst_mid_req_valid", 64'(req_valid_o), 64'(0));
        check("rst_mid_req_addr", 64'(req_addr_o), 64'(0));
        check("rst_mid_req_data", 64'(req_data_o), 64'(0));
        check("rst_mid_req_ctrl", 64'({req_write_o, req_strb_o, rsp_ready_o}), 64'(0));
        check("rst_mid_flags", 64'({busy_o, done_o, error_o, exit_code_o}), 64'(0));
        check("rst_mid_debug", 64'(debug_req_o), 64'(0));
        tick();
        rst_i = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("rst_mid_idle_busy", 64'(busy_o), 64'(0));
        check("rst_mid_idle_valid", 64'(req_valid_o), 64'(0));
        check("rst_mid_idle_flags", 64'({done_o, error_o}), 64'(0));

        run_vector(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
